uart_tx_regs: RTL and testbench



---
 rtl/uart_tx_regs.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_regs.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_regs.sv
// UART transmitter behind the 8-bit register bus: four byte registers, TX FIFO,
// bit-rate divider and a serial frame FSM (start, 8 data LSB first, optional parity, stop).
module uart_tx_regs #(
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] DEFAULT_DIV = 8'd15
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic [1:0] REGSEL,
    input  logic       BUSEN,
    input  logic       BUSW,
    input  logic [7:0] BUSWDATA,
    output logic [7:0] BUSRDATA,
    output logic       TXD,
    output logic       TX_IRQ
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_BAUD   = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    // Register file
    logic [7:0] baud_q, baud_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic       ovf_q,  ovf_d;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    cnt_q,    cnt_d;

    // Transmit FSM
    logic [2:0] state_q,   state_d;
    logic [7:0] div_q,     div_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q,   shift_d;
    logic       par_en_q,  par_en_d;
    logic       par_bit_q, par_bit_d;
    logic       txd_q,     txd_d;

    logic       wr_en;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       bit_end;
    logic       can_start;
    logic [7:0] fifo_head;

    assign wr_en      = BUSEN & BUSW;
    assign push_req   = wr_en & (REGSEL == A_TXDATA);
    assign fifo_full  = (cnt_q == 4'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == 4'd0);
    // Fullness is judged before any same-cycle pop, so push+pop while full still drops.
    assign push_ok    = push_req & ~fifo_full;
    assign fifo_head  = mem_q[rd_ptr_q];
    assign bit_end    = (div_q == 8'd0);
    assign can_start  = ctrl_q[0] & ~fifo_empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        baud_d = baud_q;
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        if (wr_en) begin
            case (REGSEL)
                A_STATUS: if (BUSWDATA[3]) ovf_d = 1'b0;
                A_BAUD:   baud_d = BUSWDATA;
                A_CTRL:   ctrl_d = BUSWDATA[2:0];
                default:  ;
            endcase
        end
        if (push_req && fifo_full) ovf_d = 1'b1;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_d = cnt_q + {3'b000, push_ok} - {3'b000, pop};
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        txd_d     = txd_q;
        pop       = 1'b0;

        // The divider reloads from the live BAUDDIV at each bit boundary.
        if (state_q != S_IDLE) div_d = bit_end ? baud_q : div_q - 8'd1;

        case (state_q)
            S_IDLE: pop = can_start;
            S_START: if (bit_end) begin
                state_d   = S_DATA;
                bit_idx_d = 3'd0;
                txd_d     = shift_q[0];
            end
            S_DATA: if (bit_end) begin
                if (bit_idx_q == 3'd7) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                    txd_d   = par_en_q ? par_bit_q : 1'b1;
                end else begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    txd_d     = shift_q[1];
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_PARITY: if (bit_end) begin
                state_d = S_STOP;
                txd_d   = 1'b1;
            end
            S_STOP: if (bit_end) begin
                if (can_start) pop = 1'b1;
                else           state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Frame parameters are captured at the pop so later CTRL writes leave this frame alone.
        if (pop) begin
            state_d   = S_START;
            div_d     = baud_q;
            txd_d     = 1'b0;
            shift_d   = fifo_head;
            par_en_d  = ctrl_q[1];
            par_bit_d = (^fifo_head) ^ ctrl_q[2];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            baud_q    <= DEFAULT_DIV;
            ctrl_q    <= 3'd0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= 4'd0;
            state_q   <= S_IDLE;
            div_q     <= 8'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            baud_q    <= baud_d;
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            txd_q     <= txd_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge PCLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= BUSWDATA;
    end

    always_comb begin
        BUSRDATA = 8'h00;
        case (REGSEL)
            A_TXDATA: BUSRDATA = 8'h00;
            A_STATUS: BUSRDATA = {cnt_q, ovf_q, fifo_full, fifo_empty, state_q != S_IDLE};
            A_BAUD:   BUSRDATA = baud_q;
            A_CTRL:   BUSRDATA = {5'b00000, ctrl_q};
            default:  BUSRDATA = 8'h00;
        endcase
    end

    assign TXD    = txd_q;
    assign TX_IRQ = ctrl_q[0] & fifo_empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_regs.sv
// Self-checking bench for uart_tx_regs: expected frames are queued as bytes are pushed
// and a line monitor decodes TXD, checking every bit value and its duration.
module tb_uart_tx_regs;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic [1:0] REGSEL = 2'd0;
    logic       BUSEN = 1'b0;
    logic       BUSW = 1'b0;
    logic [7:0] BUSWDATA = 8'h00;
    logic [7:0] BUSRDATA;
    logic       TXD;
    logic       TX_IRQ;

    uart_tx_regs #(.FIFO_DEPTH(8), .DEFAULT_DIV(8'd15)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .REGSEL(REGSEL), .BUSEN(BUSEN), .BUSW(BUSW),
        .BUSWDATA(BUSWDATA), .BUSRDATA(BUSRDATA), .TXD(TXD), .TX_IRQ(TX_IRQ)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        bit         par_odd;
        int         per_lo;   // cycles per bit for bits before sw_k
        int         per_hi;   // cycles per bit from sw_k onward
        int         sw_k;
        bit         b2b;      // must start on the edge the previous frame ended
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    bit     mon_en   = 1'b1;
    bit     mon_busy = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge PCLK);
        REGSEL = a; BUSWDATA = d; BUSW = 1'b1; BUSEN = 1'b1;
        @(posedge PCLK);
        #1;
        BUSEN = 1'b0; BUSW = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        REGSEL = a;
        #1;
        d = BUSRDATA;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic expect_frame(input logic [7:0] d, input bit pe, input bit po,
                                input int plo, input int phi, input int swk, input bit b2b);
        frame_t f;
        f.data = d; f.par_en = pe; f.par_odd = po;
        f.per_lo = plo; f.per_hi = phi; f.sw_k = swk; f.b2b = b2b;
        exp_q.push_back(f);
    endtask

    task automatic wait_idle(input int budget);
        logic [7:0] s;
        int n;
        n = 0;
        do begin
            @(negedge PCLK);
            bus_read(2'd1, s);
            n++;
        end while ((exp_q.size() != 0 || mon_busy || s[0]) && n < budget);
        check("idle_within_budget", 32'(n < budget), 32'd1);
    endtask

    // Line monitor: decodes frames starting at a 1->0 transition seen on a falling edge.
    initial begin : monitor
        logic   prev;
        frame_t e;
        int     start_cyc, last_end, per, total, nbits;
        logic   expb, obs;
        prev = 1'b1;
        last_end = -1;
        forever begin
            @(negedge PCLK);
            if (prev && !TXD && mon_en) begin
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    mon_busy = 1'b1;
                    if (e.b2b) check("b2b_no_gap", 32'(start_cyc), 32'(last_end));
                    nbits = e.par_en ? 11 : 10;
                    total = 0;
                    for (int k = 0; k < nbits; k++) begin
                        per = (k < e.sw_k) ? e.per_lo : e.per_hi;
                        if (k == 0)                       expb = 1'b0;
                        else if (k <= 8)                  expb = e.data[k-1];
                        else if (k == 9 && e.par_en)      expb = (^e.data) ^ e.par_odd;
                        else                              expb = 1'b1;
                        obs = expb;
                        for (int j = 0; j < per; j++) begin
                            if (!(k == 0 && j == 0)) @(negedge PCLK);
                            if (TXD !== expb) obs = TXD;
                        end
                        check($sformatf("frame_%02h_bit%0d", e.data, k), 32'(obs), 32'(expb));
                        total += per;
                    end
                    last_end = start_cyc + total;
                    mon_busy = 1'b0;
                end
            end
            prev = TXD;
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] d;

        // Reset state
        #23;
        @(negedge PCLK);
        PRESETn = 1'b1;
        read_check("rst_txdata", 2'd0, 8'h00);
        read_check("rst_status", 2'd1, 8'h02);
        read_check("rst_baud",   2'd2, 8'h0F);
        read_check("rst_ctrl",   2'd3, 8'h00);
        check("rst_txd", 32'(TXD), 32'd1);
        check("rst_irq", 32'(TX_IRQ), 32'd0);

        // Basic frame: 0xA5, 4 cycles per bit, no parity
        bus_write(2'd2, 8'h03);
        bus_write(2'd3, 8'h01);
        read_check("baud_rw", 2'd2, 8'h03);
        check("irq_en_empty_idle", 32'(TX_IRQ), 32'd1);
        expect_frame(8'hA5, 0, 0, 4, 4, 99, 0);
        bus_write(2'd0, 8'hA5);
        check("txd_high_at_push_edge", 32'(TXD), 32'd1);
        @(posedge PCLK); #1;
        check("txd_low_next_edge", 32'(TXD), 32'd0);
        wait_idle(200);
        check("irq_after_frame", 32'(TX_IRQ), 32'd1);
        read_check("status_after_frame", 2'd1, 8'h02);

        // Parity: even then odd on 0x07 (three ones)
        bus_write(2'd3, 8'h03);
        expect_frame(8'h07, 1, 0, 4, 4, 99, 0);
        bus_write(2'd0, 8'h07);
        wait_idle(200);
        bus_write(2'd3, 8'h07);
        read_check("ctrl_rw", 2'd3, 8'h07);
        expect_frame(8'h07, 1, 1, 4, 4, 99, 0);
        bus_write(2'd0, 8'h07);
        wait_idle(200);

        // Overflow with transmitter disabled; ninth byte dropped
        bus_write(2'd3, 8'h00);
        for (int i = 0; i < 9; i++) begin
            d = 8'(i * 37 + 11);
            if (i < 8) expect_frame(d, 0, 0, 4, 4, 99, i > 0);
            bus_write(2'd0, d);
        end
        read_check("status_full_ovf", 2'd1, 8'h8C);
        check("irq_disabled", 32'(TX_IRQ), 32'd0);
        bus_write(2'd1, 8'h00);
        read_check("status_write_ignored", 2'd1, 8'h8C);
        bus_write(2'd1, 8'h08);
        read_check("status_ovf_cleared", 2'd1, 8'h84);
        bus_write(2'd3, 8'h01);
        wait_idle(600);
        read_check("status_burst_done", 2'd1, 8'h02);

        // BAUDDIV 3 -> 1 written during data bit 2; bit 3 onward is 2 cycles
        expect_frame(8'h3C, 0, 0, 4, 2, 4, 0);
        bus_write(2'd0, 8'h3C);
        repeat (13) @(posedge PCLK);
        bus_write(2'd2, 8'h01);
        wait_idle(200);
        bus_write(2'd2, 8'h03);

        // Clearing en mid-frame: frame completes, two bytes stay queued
        expect_frame(8'h55, 0, 0, 4, 4, 99, 0);
        bus_write(2'd0, 8'h55);
        bus_write(2'd0, 8'h00);
        bus_write(2'd0, 8'h00);
        bus_write(2'd3, 8'h00);
        wait_idle(200);
        repeat (60) @(negedge PCLK);
        read_check("status_en_cleared", 2'd1, 8'h20);
        check("irq_en_cleared", 32'(TX_IRQ), 32'd0);

        // Reset during DATA of an all-zero byte
        mon_en = 1'b0;
        bus_write(2'd3, 8'h01);
        repeat (10) @(posedge PCLK);
        #2;
        check("mid_frame_low", 32'(TXD), 32'd0);
        read_check("mid_frame_busy", 2'd1, 8'h11);
        PRESETn = 1'b0;
        #1;
        check("async_reset_txd", 32'(TXD), 32'd1);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        read_check("status_after_reset", 2'd1, 8'h02);
        read_check("baud_after_reset",   2'd2, 8'h0F);
        check("irq_after_reset", 32'(TX_IRQ), 32'd0);
        mon_en = 1'b1;

        repeat (5) @(negedge PCLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
